// File: rtl/bound_flasher_p_if.sv
// Bound flasher control/status bundle: request inputs toward the flasher,
// lamp vector and FSM status back from it.
interface bound_flasher_p_if #(
  parameter int WIDTH = 16
);
  logic             flick;
  logic             repeat_en;
  logic             hold;
  logic [WIDTH-1:0] light;
  logic             busy;
  logic [2:0]       state;

  // Requester side: drives flick/repeat_en/hold, observes lamps and status.
  modport master (
    output flick,
    output repeat_en,
    output hold,
    input  light,
    input  busy,
    input  state
  );

  // Flasher side: consumes requests, presents lamps and status.
  modport slave (
    input  flick,
    input  repeat_en,
    input  hold,
    output light,
    output busy,
    output state
  );
endinterface

// File: rtl/bound_flasher_p.sv
// Bound flasher: a thermometer lamp bar that climbs to B1, falls to 0, climbs
// to B2, falls to MID, climbs to WIDTH and falls to 0. flick starts the show
// from IDLE and, when the bar sits at B1 or B2 on the second or third climb,
// kicks it back into the preceding descent. A prescaler slows stepping down to
// one step every STEP_DIV clocks, and hold freezes everything in place.
module bound_flasher_p #(
  parameter int WIDTH    = 16,
  parameter int B1       = 6,
  parameter int B2       = 11,
  parameter int MID      = 5,
  parameter int STEP_DIV = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  bound_flasher_p_if.slave    bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int DW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  localparam logic [CW-1:0] ZERO_C  = {CW{1'b0}};
  localparam logic [CW-1:0] ONE_C   = CW'(1'b1);
  localparam logic [CW-1:0] B1_C    = CW'(B1);
  localparam logic [CW-1:0] B2_C    = CW'(B2);
  localparam logic [CW-1:0] MID_C   = CW'(MID);
  localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);
  localparam logic [DW-1:0] DIV_LAST_C = DW'(STEP_DIV - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    UP1  = 3'd1,
    DN1  = 3'd2,
    UP2  = 3'd3,
    DN2  = 3'd4,
    UP3  = 3'd5,
    DN3  = 3'd6
  } state_t;

  // Thermometer code: bit i lit exactly when i < c.
  function automatic logic [WIDTH-1:0] therm(input logic [CW-1:0] c);
    logic [WIDTH-1:0] v;
    v = {WIDTH{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      v[i] = (32'(i) < 32'(c));
    end
    return v;
  endfunction

  state_t           state_q, state_d;
  state_t           nxt_state_s;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    nxt_cnt_s;
  logic [CW-1:0]    cnt_inc_s, cnt_dec_s;
  logic [DW-1:0]    div_q, div_d;
  logic [WIDTH-1:0] light_q, light_d;
  logic             busy_q, busy_d;
  logic             tick_s;
  logic             kick_s;
  logic             state_illegal_s;

  // Prescaler: advance each unheld clock, wrap at STEP_DIV-1 and flag the step tick.
  always_comb begin
    div_d  = div_q;
    tick_s = 1'b0;
    if (bus.hold) begin
      div_d  = div_q;
      tick_s = 1'b0;
    end else if (div_q == DIV_LAST_C) begin
      div_d  = {DW{1'b0}};
      tick_s = 1'b1;
    end else begin
      div_d  = div_q + DW'(1'b1);
      tick_s = 1'b0;
    end
  end

  // Saturating neighbours of cnt so the count can never wrap out of 0..WIDTH.
  always_comb begin
    cnt_inc_s = cnt_q;
    cnt_dec_s = cnt_q;
    if (cnt_q < WIDTH_C) begin
      cnt_inc_s = cnt_q + ONE_C;
    end else begin
      cnt_inc_s = WIDTH_C;
    end
    if (cnt_q != ZERO_C) begin
      cnt_dec_s = cnt_q - ONE_C;
    end else begin
      cnt_dec_s = ZERO_C;
    end
  end

  // Kickback is only meaningful at the two bound counts.
  always_comb begin
    kick_s = bus.flick && ((cnt_q == B1_C) || (cnt_q == B2_C));
  end

  // Step rules: where the bar goes on a tick from the current state and count.
  always_comb begin
    nxt_state_s = state_q;
    nxt_cnt_s   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.flick) begin
          nxt_state_s = UP1;
          nxt_cnt_s   = ONE_C;
        end else begin
          nxt_state_s = IDLE;
          nxt_cnt_s   = ZERO_C;
        end
      end
      UP1: begin
        if (cnt_q == B1_C) begin
          nxt_state_s = DN1;
          nxt_cnt_s   = B1_C - ONE_C;
        end else begin
          nxt_state_s = UP1;
          nxt_cnt_s   = cnt_inc_s;
        end
      end
      DN1: begin
        if (cnt_q == ZERO_C) begin
          nxt_state_s = UP2;
          nxt_cnt_s   = ONE_C;
        end else begin
          nxt_state_s = DN1;
          nxt_cnt_s   = cnt_dec_s;
        end
      end
      UP2: begin
        if (kick_s) begin
          nxt_state_s = DN1;
          nxt_cnt_s   = cnt_dec_s;
        end else if (cnt_q == B2_C) begin
          nxt_state_s = DN2;
          nxt_cnt_s   = cnt_dec_s;
        end else begin
          nxt_state_s = UP2;
          nxt_cnt_s   = cnt_inc_s;
        end
      end
      DN2: begin
        if (cnt_q == MID_C) begin
          nxt_state_s = UP3;
          nxt_cnt_s   = MID_C + ONE_C;
        end else begin
          nxt_state_s = DN2;
          nxt_cnt_s   = cnt_dec_s;
        end
      end
      UP3: begin
        if (kick_s) begin
          nxt_state_s = DN2;
          nxt_cnt_s   = cnt_dec_s;
        end else if (cnt_q == WIDTH_C) begin
          nxt_state_s = DN3;
          nxt_cnt_s   = WIDTH_C - ONE_C;
        end else begin
          nxt_state_s = UP3;
          nxt_cnt_s   = cnt_inc_s;
        end
      end
      DN3: begin
        if (cnt_q != ZERO_C) begin
          nxt_state_s = DN3;
          nxt_cnt_s   = cnt_dec_s;
        end else if (bus.repeat_en || bus.flick) begin
          nxt_state_s = UP1;
          nxt_cnt_s   = ONE_C;
        end else begin
          nxt_state_s = IDLE;
          nxt_cnt_s   = ZERO_C;
        end
      end
      default: begin
        nxt_state_s = IDLE;
        nxt_cnt_s   = ZERO_C;
      end
    endcase
  end

  // Apply a step only on a tick; an unused state code falls back to IDLE at once.
  always_comb begin
    state_illegal_s = (state_q > DN3);
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_illegal_s) begin
      state_d = IDLE;
      cnt_d   = ZERO_C;
    end else if (tick_s) begin
      state_d = nxt_state_s;
      cnt_d   = nxt_cnt_s;
    end else begin
      state_d = state_q;
      cnt_d   = cnt_q;
    end
  end

  // Outputs are precomputed from the next state so they can be registered in step.
  always_comb begin
    light_d = therm(cnt_d);
    busy_d  = (state_d != IDLE);
  end

  // State, count, prescaler and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= ZERO_C;
      div_q   <= {DW{1'b0}};
      light_q <= {WIDTH{1'b0}};
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      light_q <= light_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.light = light_q;
  assign bus.busy  = busy_q;
  assign bus.state = state_q;

endmodule

// File: tb/tb_bound_flasher_p.sv
// Bench for bound_flasher_p: two instances (STEP_DIV=1 and STEP_DIV=4) share
// stimulus; a table-driven phase model predicts lamps/state, expectations go
// through a queue to a negedge monitor, plus fixed-value directed checks.
module tb_bound_flasher_p;

  localparam int W   = 16;
  localparam int B1  = 6;
  localparam int B2  = 11;
  localparam int MID = 5;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  bound_flasher_p_if #(.WIDTH(W)) bus0 ();
  bound_flasher_p_if #(.WIDTH(W)) bus1 ();

  bound_flasher_p #(.WIDTH(W), .B1(B1), .B2(B2), .MID(MID), .STEP_DIV(1)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0)
  );
  bound_flasher_p #(.WIDTH(W), .B1(B1), .B2(B2), .MID(MID), .STEP_DIV(4)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1)
  );

  typedef struct packed {
    logic [15:0] l0;
    logic [2:0]  s0;
    logic        b0;
    logic [15:0] l1;
    logic [2:0]  s1;
    logic        b1;
  } exp_t;

  exp_t sbq[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model: phase 0 = idle, odd phases climb to peak[], even phases fall to flr[].
  int sd[2]    = '{1, 4};
  int peak[7]  = '{0, B1, 0, B2, 0, W, 0};
  int flr[7]   = '{0, 0, 0, 0, MID, 0, 0};
  int m_phase[2];
  int m_cnt[2];
  int m_act[2];

  function automatic logic [15:0] therm(int c);
    logic [63:0] one;
    one = 64'd1;
    return 16'((one << c) - 64'd1);
  endfunction

  function automatic void model_reset(int k);
    m_phase[k] = 0;
    m_cnt[k]   = 0;
    m_act[k]   = 0;
  endfunction

  function automatic void model_step(int k, logic f, logic r, logic h, logic rn);
    int p;
    int c;
    if (!rn) begin
      model_reset(k);
      return;
    end
    if (h) return;
    m_act[k]++;
    if ((m_act[k] % sd[k]) != 0) return;
    p = m_phase[k];
    c = m_cnt[k];
    if (p == 0) begin
      if (f) begin p = 1; c = 1; end
      else c = 0;
    end else if ((p == 3 || p == 5) && f && (c == B1 || c == B2)) begin
      p = p - 1;
      c = c - 1;
    end else if ((p % 2) == 1) begin
      if (c == peak[p]) begin p = p + 1; c = c - 1; end
      else c = c + 1;
    end else begin
      if (c == flr[p]) begin
        if (p == 6) begin
          if (r || f) begin p = 1; c = 1; end
          else begin p = 0; c = 0; end
        end else begin
          p = p + 1;
          c = c + 1;
        end
      end else c = c - 1;
    end
    m_phase[k] = p;
    m_cnt[k]   = c;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, expv);
    end
  endtask

  // One clock: drive inputs after the falling edge, step the model after the rising edge.
  task automatic cycle(logic f, logic r, logic h, logic rn);
    exp_t e;
    @(negedge clk);
    #1;
    reset_n        = rn;
    bus0.flick     = f;  bus1.flick     = f;
    bus0.repeat_en = r;  bus1.repeat_en = r;
    bus0.hold      = h;  bus1.hold      = h;
    if (!rn) begin
      model_reset(0);
      model_reset(1);
    end
    @(posedge clk);
    #1;
    model_step(0, f, r, h, rn);
    model_step(1, f, r, h, rn);
    e.l0 = therm(m_cnt[0]); e.s0 = 3'(m_phase[0]); e.b0 = (m_phase[0] != 0);
    e.l1 = therm(m_cnt[1]); e.s1 = 3'(m_phase[1]); e.b1 = (m_phase[1] != 0);
    sbq.push_back(e);
  endtask

  // Monitor: compare both instances against the queued prediction on each falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        n_vec++;
        if ({bus0.light, bus0.state, bus0.busy} !== {e.l0, e.s0, e.b0}) begin
          n_err++;
          $display("FAIL sb_div1 t=%0t got light=%h state=%0d busy=%b want light=%h state=%0d busy=%b",
                   $time, bus0.light, bus0.state, bus0.busy, e.l0, e.s0, e.b0);
        end
        n_vec++;
        if ({bus1.light, bus1.state, bus1.busy} !== {e.l1, e.s1, e.b1}) begin
          n_err++;
          $display("FAIL sb_div4 t=%0t got light=%h state=%0d busy=%b want light=%h state=%0d busy=%b",
                   $time, bus1.light, bus1.state, bus1.busy, e.l1, e.s1, e.b1);
        end
      end
    end
  end

  // Watchdog so the run can never hang.
  initial begin
    #2000000;
    $display("FAIL watchdog t=%0t got=running want=finished", $time);
    $fatal(1, "watchdog expired");
  end

  // Stimulus: directed scenarios with fixed expected lamps, then randomized traffic.
  initial begin
    int   ed[8]  = '{0, 5, 11, 22, 28, 39, 55, 56};
    logic [15:0] lv[8] = '{16'h0001, 16'h003F, 16'h0000, 16'h07FF,
                           16'h001F, 16'hFFFF, 16'h0000, 16'h0000};
    logic f;
    logic r;
    logic h;
    logic rn;

    reset_n = 1'b0;
    bus0.flick = 1'b0; bus0.repeat_en = 1'b0; bus0.hold = 1'b0;
    bus1.flick = 1'b0; bus1.repeat_en = 1'b0; bus1.hold = 1'b0;
    model_reset(0);
    model_reset(1);

    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_light", 32'(bus0.light), 32'h0);
    chk("rst_state", 32'(bus0.state), 32'h0);
    chk("rst_busy",  32'(bus0.busy),  32'h0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);

    // Full default sequence from a single one-clock flick.
    for (int e = 0; e <= 57; e++) begin
      cycle(e == 0, 1'b0, 1'b0, 1'b1);
      for (int j = 0; j < 8; j++) begin
        if (ed[j] == e) chk("seq_light", 32'(bus0.light), 32'(lv[j]));
      end
      if (e == 56) begin
        chk("seq_end_state", 32'(bus0.state), 32'h0);
        chk("seq_end_busy",  32'(bus0.busy),  32'h0);
      end
    end

    // repeat_en held: DN3 end goes straight back into UP1.
    for (int e = 0; e <= 57; e++) begin
      cycle(e == 0, 1'b1, 1'b0, 1'b1);
      if (e == 55) chk("rep_floor", 32'(bus0.light), 32'h0000);
      if (e == 56) begin
        chk("rep_light", 32'(bus0.light), 32'h0001);
        chk("rep_state", 32'(bus0.state), 32'h1);
      end
    end

    // UP2 kickback at B1, then asynchronous reset in DN2.
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    for (int e = 0; e <= 36; e++) begin
      cycle((e == 0) || (e == 18), 1'b0, 1'b0, 1'b1);
      if (e == 17) chk("up2_at_b1", 32'(bus0.light), 32'h003F);
      if (e == 18) begin
        chk("kick1_light", 32'(bus0.light), 32'h001F);
        chk("kick1_state", 32'(bus0.state), 32'h2);
      end
      if (e == 24) begin
        chk("kick1_restart_light", 32'(bus0.light), 32'h0001);
        chk("kick1_restart_state", 32'(bus0.state), 32'h3);
      end
      if (e == 36) chk("dn2_state", 32'(bus0.state), 32'h4);
    end
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    model_reset(0);
    model_reset(1);
    #1;
    chk("async_light", 32'(bus0.light), 32'h0);
    chk("async_state", 32'(bus0.state), 32'h0);
    chk("async_busy",  32'(bus0.busy),  32'h0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    for (int e = 0; e < 6; e++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
    chk("post_rst_idle", 32'(bus0.state), 32'h0);

    // UP3 kickback at B2 into DN2, descent to MID, UP3 again.
    for (int e = 0; e <= 42; e++) begin
      cycle((e == 0) || (e == 35), 1'b0, 1'b0, 1'b1);
      if (e == 34) chk("up3_at_b2", 32'(bus0.light), 32'h07FF);
      if (e == 35) begin
        chk("kick2_light", 32'(bus0.light), 32'h03FF);
        chk("kick2_state", 32'(bus0.state), 32'h4);
      end
      if (e == 40) chk("kick2_floor", 32'(bus0.light), 32'h001F);
      if (e == 41) begin
        chk("kick2_up3_light", 32'(bus0.light), 32'h003F);
        chk("kick2_up3_state", 32'(bus0.state), 32'h5);
      end
    end

    // STEP_DIV=4 instance: steps every 4 clocks, frozen under hold, flick ignored.
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    for (int e = 1; e <= 4; e++) cycle(1'b1, 1'b0, 1'b0, 1'b1);
    chk("div4_first", 32'(bus1.light), 32'h0001);
    for (int e = 5; e <= 13; e++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      if (e == 7) chk("div4_wait", 32'(bus1.light), 32'h0001);
    end
    chk("div4_third", 32'(bus1.light), 32'h0007);
    for (int e = 0; e < 10; e++) begin
      cycle(1'b1, 1'b0, 1'b1, 1'b1);
      chk("hold_light", 32'(bus1.light), 32'h0007);
      chk("hold_state", 32'(bus1.state), 32'h1);
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    chk("hold_resume_wait", 32'(bus1.light), 32'h0007);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    chk("hold_resume_step", 32'(bus1.light), 32'h000F);

    // Randomized traffic checked through the scoreboard.
    for (int i = 0; i < 3000; i++) begin
      f  = ($urandom_range(0, 3) == 0);
      r  = ($urandom_range(0, 7) == 0);
      h  = ($urandom_range(0, 11) == 0);
      rn = ($urandom_range(0, 299) != 0);
      cycle(f, r, h, rn);
    end

    repeat (2) @(negedge clk);
    #1;
    chk("sb_drain", 32'(sbq.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bound_flasher_p.md
BOUND_FLASHER_P -- requirements
Module: bound_flasher_p

Interface
REQ-001 Parameter WIDTH, 16, lamp count; legal range 4..64.
REQ-002 Parameter B1, 6, lamps lit at the first peak and the low kickback point; legal range MID < B1 < B2.
REQ-003 Parameter B2, 11, lamps lit at the second peak and the high kickback point; legal range B2 < WIDTH.
REQ-004 Parameter MID, 5, floor of the second descent; legal range 1 <= MID.
REQ-005 Parameter STEP_DIV, 1, clocks per step tick; legal range 1..65535.
REQ-006 clk  input  1  single clock; all state changes on the rising edge.
REQ-007 reset_n  input  1  asynchronous active-low reset.
REQ-008 flick  input  1  start request in IDLE; kickback request at kickback points.
REQ-009 repeat_en  input  1  on 1, restart automatically at the end of a sequence.
REQ-010 hold  input  1  on 1, freeze all internal state.
REQ-011 light  output  WIDTH  thermometer lamp vector; bits [cnt-1:0] set.
REQ-012 busy  output  1  1 when state is not IDLE.
REQ-013 state  output  3  current FSM state code.

Function
REQ-014 The block SHALL hold a lamp count cnt (0..WIDTH) and SHALL drive light[i] = 1 exactly when i < cnt.
REQ-015 State codes SHALL be IDLE=0, UP1=1, DN1=2, UP2=3, DN2=4, UP3=5, DN3=6; codes 7 and above SHALL recover to IDLE with cnt=0 on the next edge.
REQ-016 A prescaler div (0..STEP_DIV-1) SHALL increment each clock and wrap; tick = (div == STEP_DIV-1); STEP_DIV=1 gives a tick every clock.
REQ-017 The FSM and cnt SHALL change only on tick edges; flick and repeat_en SHALL be sampled only on tick edges.
REQ-018 While hold=1, div, state and cnt SHALL be frozen and flick SHALL be ignored; counting resumes from the frozen values when hold=0.
REQ-019 IDLE: if flick=1 at a tick, go to UP1 with cnt=1 on that edge; otherwise remain in IDLE with cnt=0.
REQ-020 UP1: if cnt == B1, go to DN1 with cnt=B1-1; otherwise increment cnt.
REQ-021 DN1: if cnt == 0, go to UP2 with cnt=1; otherwise decrement cnt.
REQ-022 UP2: if flick=1 and cnt is B1 or B2, kick back to DN1 with cnt-1 (kickback has priority); else if cnt == B2, go to DN2 with cnt-1; otherwise increment cnt.
REQ-023 DN2: if cnt == MID, go to UP3 with cnt=MID+1; otherwise decrement cnt.
REQ-024 UP3: if flick=1 and cnt is B1 or B2, kick back to DN2 with cnt-1; else if cnt == WIDTH, go to DN3 with cnt=WIDTH-1; otherwise increment cnt.
REQ-025 DN3: if cnt == 0 and (repeat_en or flick) = 1, go to UP1 with cnt=1; if cnt == 0 otherwise, go to IDLE; if cnt > 0, decrement cnt.
REQ-026 flick SHALL be ignored in UP1, DN1, DN2, and DN3 (except at DN3 end), and in UP2/UP3 at counts other than B1 and B2.
REQ-027 Kickback SHALL be repeatable without limit; each kickback restarts the descent of the preceding DN state.
REQ-028 cnt SHALL never leave 0..WIDTH; no arithmetic wrap is permitted.
REQ-029 busy SHALL equal (state != IDLE); state SHALL be the registered state code.

Reset
REQ-030 reset_n=0 SHALL immediately force state=IDLE, cnt=0, div=0, light=0, busy=0, state=0, independent of clk and hold.
REQ-031 Reset asserted mid-sequence SHALL abort the sequence; after release, the block SHALL need a new flick (or repeat_en at no point) to restart.
REQ-032 The first tick edge after reset release SHALL be at least STEP_DIV clocks after release.

Verification
REQ-033 Defaults, single 1-clock flick after reset -> edge 0: light=0x0001; edge 5: 0x003F; edge 11: 0x0000; edge 22: 0x07FF; edge 28: 0x001F; edge 39: 0xFFFF; edge 55: 0x0000; edge 56: IDLE, busy=0.
REQ-034 Defaults, UP2 with flick=1 when cnt=6 (light=0x003F) -> next light=0x001F, state=DN1, then descent to 0 and UP2 restarts.
REQ-035 Defaults, UP3 with flick=1 at cnt=11 (light=0x07FF) -> state=DN2, light=0x03FF, descent to 0x001F, then UP3 again.
REQ-036 repeat_en=1 through DN3 end -> cnt=0 then UP1 with light=0x0001 on the next tick, no IDLE; with repeat_en=0 and flick=0 -> IDLE.
REQ-037 STEP_DIV=4 with hold=1 for 10 clocks mid-UP1 -> light changes every 4 clocks and is frozen during hold; flick during hold produces no kickback.
REQ-038 reset_n=0 pulsed asynchronously mid-DN2 -> light=0, state=0 before the next clk edge; stays IDLE until flick.
